// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch / load-store memory port arbiter.
// State and in-flight tag encodings plus the memory half width.
package mem_arb_pkg;

   localparam int HALF_W = 16;

   typedef enum logic {
      ST_IDLE,
      ST_D_HI
   } state_e;

   typedef enum logic [2:0] {
      TAG_NONE,
      TAG_IF,
      TAG_D_LO,
      TAG_D_HI,
      TAG_D_16
   } tag_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one 16-bit synchronous memory port between fetch and load/store.
// Data wins ties unless fetch is owed a slot; 32-bit data goes low half first.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [HALF_W-1:0] if_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic              d_word_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [31:0]       d_wdata_i,
   output logic              d_gnt_o,
   output logic              d_err_o,
   output logic              d_rvalid_o,
   output logic [31:0]       d_rdata_o,
   output logic              stall_fetch_o,
   output logic              mem_re_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [HALF_W-1:0] mem_wdata_o,
   input  logic [HALF_W-1:0] mem_rdata_i
);

   state_e            state_q, state_d;
   tag_e              tag_q, tag_d;
   logic              owed_q, owed_d;
   logic [HALF_W-1:0] lo_q, lo_d;
   logic [ADDR_W-1:0] d_base;

   assign d_base = {d_addr_i[ADDR_W-1:1], 1'b0};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         tag_q   <= TAG_NONE;
         owed_q  <= 1'b0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         owed_q  <= owed_d;
         lo_q    <= lo_d;
      end
   end

   // Beats are suppressed while reset is held so every output reads 0.
   always_comb begin
      state_d       = state_q;
      tag_d         = TAG_NONE;
      owed_d        = owed_q;
      if_gnt_o      = 1'b0;
      d_gnt_o       = 1'b0;
      d_err_o       = 1'b0;
      mem_re_o      = 1'b0;
      mem_we_o      = 1'b0;
      mem_addr_o    = '0;
      mem_wdata_o   = '0;
      stall_fetch_o = 1'b0;
      if (rst_ni) begin
         unique case (state_q)
            ST_IDLE: begin
               if (d_req_i && !owed_q) begin
                  mem_addr_o  = d_base;
                  mem_we_o    = d_we_i;
                  mem_re_o    = !d_we_i;
                  mem_wdata_o = d_wdata_i[15:0];
                  if (d_word_i) begin
                     state_d = ST_D_HI;
                     tag_d   = d_we_i ? TAG_NONE : TAG_D_LO;
                  end else begin
                     d_gnt_o = 1'b1;
                     d_err_o = d_addr_i[0];
                     tag_d   = d_we_i ? TAG_NONE : TAG_D_16;
                  end
               end else if (if_req_i) begin
                  if_gnt_o   = 1'b1;
                  mem_re_o   = 1'b1;
                  mem_addr_o = {if_addr_i[ADDR_W-1:1], 1'b0};
                  tag_d      = TAG_IF;
               end
            end
            ST_D_HI: begin
               state_d     = ST_IDLE;
               mem_addr_o  = d_base + ADDR_W'(2);
               mem_we_o    = d_we_i;
               mem_re_o    = !d_we_i;
               mem_wdata_o = d_wdata_i[31:16];
               d_gnt_o     = 1'b1;
               d_err_o     = d_addr_i[0];
               tag_d       = d_we_i ? TAG_NONE : TAG_D_HI;
            end
         endcase
         if (d_gnt_o && if_req_i) begin
            owed_d = 1'b1;
         end else if (if_gnt_o) begin
            owed_d = 1'b0;
         end
         stall_fetch_o = if_req_i & ~if_gnt_o;
      end
   end

   always_comb begin
      lo_d        = lo_q;
      if_rvalid_o = 1'b0;
      if_rdata_o  = '0;
      d_rvalid_o  = 1'b0;
      d_rdata_o   = '0;
      unique case (tag_q)
         TAG_IF: begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = mem_rdata_i;
         end
         TAG_D_LO: lo_d = mem_rdata_i;
         TAG_D_HI: begin
            d_rvalid_o = 1'b1;
            d_rdata_o  = {mem_rdata_i, lo_q};
         end
         TAG_D_16: begin
            d_rvalid_o = 1'b1;
            d_rdata_o  = {16'h0, mem_rdata_i};
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic,
// all checked against a transaction-level model with its own memory image.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_gnt, if_rvalid;
   logic [15:0] if_rdata;
   logic        d_req = 1'b0, d_we = 1'b0, d_word = 1'b0;
   logic [31:0] d_addr = '0, d_wdata = '0;
   logic        d_gnt, d_err, d_rvalid;
   logic [31:0] d_rdata;
   logic        stall, mem_re, mem_we;
   logic [31:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .if_req_i(if_req), .if_addr_i(if_addr),
      .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
      .d_req_i(d_req), .d_we_i(d_we), .d_word_i(d_word),
      .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_gnt_o(d_gnt), .d_err_o(d_err),
      .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
      .stall_fetch_o(stall), .mem_re_o(mem_re), .mem_we_o(mem_we),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata)
   );

   // Initial memory contents; a few addresses carry the scenario values.
   function automatic logic [15:0] dflt(input logic [31:0] a);
      case (a)
         32'h100: return 16'hA1B2;
         32'h102: return 16'hC3D4;
         32'h200: return 16'h5678;
         32'h202: return 16'h1234;
         32'h300: return 16'h9ABC;
         default: return a[16:1] ^ 16'h5A5A;
      endcase
   endfunction

   // Memory macro seen by the DUT.
   logic [15:0] env_mem [65536];
   bit          env_wr  [65536];
   always @(posedge clk) begin
      if (mem_we) begin
         env_mem[mem_addr[16:1]] <= mem_wdata;
         env_wr[mem_addr[16:1]]  <= 1'b1;
      end
      if (mem_re)
         mem_rdata <= env_wr[mem_addr[16:1]] ?
                      env_mem[mem_addr[16:1]] : dflt(mem_addr);
   end

   // Reference model memory image.
   logic [15:0] mm    [65536];
   bit          mm_wr [65536];

   function automatic logic [15:0] mrd(input logic [31:0] a);
      return mm_wr[a[16:1]] ? mm[a[16:1]] : dflt(a);
   endfunction

   bit          m_hi = 0, m_owed = 0;
   logic [15:0] m_lo = '0;
   bit          e_ifv = 0, e_dv = 0;
   logic [15:0] e_ifd = '0;
   logic [31:0] e_dd = '0;
   bit          last_ifg = 0, last_dg = 0;

   task automatic chk(input string t, input logic [31:0] o,
                      input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", t, o, e);
      end
   endtask

   task automatic mwrite(input logic [31:0] a, input logic [15:0] v);
      mm[a[16:1]]    = v;
      mm_wr[a[16:1]] = 1'b1;
   endtask

   // Called just after a falling edge with inputs set for this cycle.
   task automatic cycle();
      logic [31:0] a, base, xaddr, ndd;
      logic [15:0] xwd, nifd;
      bit          xig, xdg, xerr, xre, xwe, nifv, ndv;
      #1;
      if (!rst_n) begin
         chk("rst_if_gnt", if_gnt, 0);
         chk("rst_d_gnt", d_gnt, 0);
         chk("rst_d_err", d_err, 0);
         chk("rst_stall", stall, 0);
         chk("rst_mem_re", mem_re, 0);
         chk("rst_mem_we", mem_we, 0);
         chk("rst_mem_addr", mem_addr, 0);
         chk("rst_mem_wdata", mem_wdata, 0);
         chk("rst_if_rvalid", if_rvalid, 0);
         chk("rst_if_rdata", if_rdata, 0);
         chk("rst_d_rvalid", d_rvalid, 0);
         chk("rst_d_rdata", d_rdata, 0);
         m_hi = 0; m_owed = 0; m_lo = '0;
         e_ifv = 0; e_dv = 0;
         last_ifg = 0; last_dg = 0;
      end else begin
         xig = 0; xdg = 0; xerr = 0; xre = 0; xwe = 0;
         xaddr = '0; xwd = '0;
         nifv = 0; ndv = 0; nifd = '0; ndd = '0;
         base = {d_addr[31:1], 1'b0};
         if (m_hi) begin
            a = base + 32'd2;
            xaddr = a; xdg = 1; xerr = d_addr[0];
            if (d_we) begin
               xwe = 1; xwd = d_wdata[31:16]; mwrite(a, xwd);
            end else begin
               xre = 1; ndv = 1; ndd = {mrd(a), m_lo};
            end
            m_hi = 0;
         end else if (d_req && !m_owed) begin
            xaddr = base;
            if (d_we) begin
               xwe = 1; xwd = d_wdata[15:0]; mwrite(base, xwd);
            end else begin
               xre = 1;
            end
            if (d_word) begin
               m_hi = 1;
               if (!d_we) m_lo = mrd(base);
            end else begin
               xdg = 1; xerr = d_addr[0];
               if (!d_we) begin
                  ndv = 1; ndd = {16'h0, mrd(base)};
               end
            end
         end else if (if_req) begin
            xig = 1; xre = 1;
            xaddr = {if_addr[31:1], 1'b0};
            nifv = 1; nifd = mrd(xaddr);
         end
         chk("if_gnt", if_gnt, xig);
         chk("d_gnt", d_gnt, xdg);
         chk("d_err", d_err, xerr);
         chk("stall", stall, if_req & ~xig);
         chk("mem_re", mem_re, xre);
         chk("mem_we", mem_we, xwe);
         if (xre || xwe) chk("mem_addr", mem_addr, xaddr);
         if (xwe) chk("mem_wdata", mem_wdata, xwd);
         chk("if_rvalid", if_rvalid, e_ifv);
         if (e_ifv) chk("if_rdata", if_rdata, e_ifd);
         chk("d_rvalid", d_rvalid, e_dv);
         if (e_dv) chk("d_rdata", d_rdata, e_dd);
         if (xdg && if_req) m_owed = 1;
         else if (xig) m_owed = 0;
         e_ifv = nifv; e_ifd = nifd;
         e_dv = ndv; e_dd = ndd;
         last_ifg = xig; last_dg = xdg;
      end
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      // reset state
      rst_n = 0;
      cycle();
      cycle();
      rst_n = 1;

      // fetch 0x100 then 0x102
      if_req = 1; if_addr = 32'h100;
      cycle();
      #1 chk("tp_fetch0", if_rdata, 16'hA1B2);
      if_addr = 32'h102;
      cycle();
      #1 chk("tp_fetch1", if_rdata, 16'hC3D4);
      if_req = 0;
      cycle();

      // 32-bit load at 0x200
      d_req = 1; d_we = 0; d_word = 1; d_addr = 32'h200;
      cycle();
      cycle();
      #1 chk("tp_ld32", d_rdata, 32'h12345678);
      d_req = 0;
      cycle();

      // 32-bit store across the address wrap, then read it back
      d_req = 1; d_we = 1; d_word = 1;
      d_addr = 32'hFFFF_FFFE; d_wdata = 32'hDEADBEEF;
      cycle();
      cycle();
      d_req = 0;
      cycle();
      d_req = 1; d_we = 0;
      cycle();
      cycle();
      #1 chk("tp_wrap_rb", d_rdata, 32'hDEADBEEF);
      d_req = 0;
      cycle();

      // both requesters held: 16-bit then 32-bit data
      d_req = 1; d_we = 0; d_word = 0; d_addr = 32'h110;
      if_req = 1; if_addr = 32'h104;
      repeat (6) cycle();
      d_req = 0;
      cycle();
      d_req = 1; d_word = 1;
      repeat (6) cycle();
      d_req = 0;
      cycle();
      if_req = 0;
      cycle();

      // misaligned 16-bit load
      d_req = 1; d_we = 0; d_word = 0; d_addr = 32'h301;
      cycle();
      #1 chk("tp_misal", d_rdata, 32'h0000_9ABC);
      d_req = 0;
      cycle();

      // reset during the high beat of a 32-bit load
      d_req = 1; d_we = 0; d_word = 1; d_addr = 32'h200;
      cycle();
      rst_n = 0;
      cycle();
      d_req = 0;
      rst_n = 1;
      cycle();
      if_req = 1; if_addr = 32'h0;
      cycle();
      if_req = 0;
      cycle();

      // random traffic
      for (int i = 0; i < 800; i++) begin
         if (!if_req || last_ifg) begin
            if_req  = ($urandom_range(0, 3) != 0);
            if_addr = 32'h100 + 32'($urandom_range(0, 31));
         end
         if (!d_req || last_dg) begin
            d_req   = ($urandom_range(0, 2) != 0);
            d_we    = 1'($urandom_range(0, 1));
            d_word  = 1'($urandom_range(0, 1));
            d_wdata = $urandom;
            if ($urandom_range(0, 7) == 0)
               d_addr = 32'hFFFF_FFFE + 32'($urandom_range(0, 1));
            else
               d_addr = 32'h100 + 32'($urandom_range(0, 31));
         end
         cycle();
      end
      if_req = 0; d_req = 0;
      cycle();
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
